// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared constants and types for the pipelined ARM-lite (LEGv8 subset) CPU.
//   - PC_W / INSTR_W   : architectural PC and instruction widths
//   - NOP_INSTR        : bubble encoding loaded into pipeline registers
//   - HALT_INSTR       : "B 0" self-loop marking the end of a program
//   - ifid_t           : IF/ID register payload, also used by the hazard unit
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'hD503201F;
   localparam logic [INSTR_W-1:0] HALT_INSTR = 32'h14000000;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               valid;
   } ifid_t;

endpackage : cpu_pkg

// File: rtl/branch_target_calc.sv
// ---------------------------------------------------------------------------
// branch_target_calc
//   Combinational branch-target adder for B / CBZ / B.cond.
//   target = br_pc + (sext(imm) << 2), modulo 2^PC_W (wrap is silent).
//   Ports:
//     br_pc     in  PC_W  PC of the branch instruction
//     br_imm26  in  26    B offset field (words)
//     br_imm19  in  19    CBZ / B.cond offset field (words)
//     uncond_br in  1     1 selects imm26, 0 selects imm19
//     target    out PC_W  byte address of the branch destination
// ---------------------------------------------------------------------------
module branch_target_calc #(
   parameter int PC_W = cpu_pkg::PC_W
) (
   input  logic [PC_W-1:0] br_pc,
   input  logic [25:0]     br_imm26,
   input  logic [18:0]     br_imm19,
   input  logic            uncond_br,
   output logic [PC_W-1:0] target
);

   logic signed [PC_W-1:0] off;
   logic        [PC_W-1:0] off_bytes;

   always_comb begin
      if (uncond_br) begin
         off = {{(PC_W-26){br_imm26[25]}}, br_imm26};
      end else begin
         off = {{(PC_W-19){br_imm19[18]}}, br_imm19};
      end
      // Word offset to byte offset; the top two bits fall off, matching the
      // modulo-2^PC_W address arithmetic.
      off_bytes = off << 2;
      target    = br_pc + off_bytes;
   end

endmodule : branch_target_calc

// File: rtl/pipelined_fetch_stage.sv
// ---------------------------------------------------------------------------
// pipelined_fetch_stage
//   IF stage plus IF/ID pipeline register. Owns the PC, drives the
//   instruction-memory address, applies redirects from ID (one architectural
//   delay slot), holds under stall and remembers a redirect that arrives
//   while stalled.
//   Ports:
//     clk, reset   clock / synchronous active-high reset
//     imem_addr    out  PC_W     fetch address (= PC), combinational
//     imem_data    in   INSTR_W  instruction at imem_addr, same cycle
//     stall        in   1        hold PC and IF/ID
//     flush        in   1        load a bubble into IF/ID
//     br_taken     in   1        ID resolved a taken branch this cycle
//     uncond_br    in   1        1 = B (imm26), 0 = CBZ/B.cond (imm19)
//     br_pc        in   PC_W     PC of the branch in ID
//     br_imm26     in   26       B offset
//     br_imm19     in   19       CBZ/B.cond offset
//     ifid_instr   out  INSTR_W  registered instruction to ID
//     ifid_pc      out  PC_W     PC of ifid_instr
//     ifid_valid   out  1        ifid_instr is a real instruction
//     halted       out  1        sticky: HALT_INSTR has entered IF/ID
// ---------------------------------------------------------------------------
module pipelined_fetch_stage #(
   parameter int                         PC_W       = cpu_pkg::PC_W,
   parameter int                         INSTR_W    = cpu_pkg::INSTR_W,
   parameter logic [cpu_pkg::INSTR_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR,
   parameter logic [cpu_pkg::INSTR_W-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               stall,
   input  logic               flush,
   input  logic               br_taken,
   input  logic               uncond_br,
   input  logic [PC_W-1:0]    br_pc,
   input  logic [25:0]        br_imm26,
   input  logic [18:0]        br_imm19,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic               halted
);

   import cpu_pkg::*;

   localparam logic [INSTR_W-1:0] NOP_W  = INSTR_W'(NOP_INSTR);
   localparam logic [INSTR_W-1:0] HALT_W = INSTR_W'(HALT_INSTR);
   localparam logic [PC_W-1:0]    PC_INC = PC_W'(4);

   logic [PC_W-1:0]    pc_q,          pc_d;
   logic               pend_valid_q,  pend_valid_d;
   logic [PC_W-1:0]    pend_target_q, pend_target_d;
   logic [INSTR_W-1:0] ifid_instr_q,  ifid_instr_d;
   logic [PC_W-1:0]    ifid_pc_q,     ifid_pc_d;
   logic               ifid_valid_q,  ifid_valid_d;
   logic               halted_q,      halted_d;
   logic [PC_W-1:0]    br_target;

   branch_target_calc #(
      .PC_W (PC_W)
   ) u_btc (
      .br_pc     (br_pc),
      .br_imm26  (br_imm26),
      .br_imm19  (br_imm19),
      .uncond_br (uncond_br),
      .target    (br_target)
   );

   assign imem_addr = pc_q;

   always_comb begin
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_valid_d  = ifid_valid_q;
      halted_d      = halted_q;

      if (stall) begin
         // Everything holds; a redirect is parked until the stall releases.
         // A later redirect in the same stall simply overwrites it.
         if (br_taken) begin
            pend_target_d = br_target;
            pend_valid_d  = 1'b1;
         end
      end else begin
         // A live redirect is newer than anything parked, so it wins.
         if (br_taken) begin
            pc_d         = br_target;
            pend_valid_d = 1'b0;
         end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
         end else begin
            pc_d = pc_q + PC_INC;
         end

         // The delay-slot instruction fetched this cycle always enters IF/ID;
         // only flush turns it into a bubble.
         ifid_pc_d = pc_q;
         if (flush) begin
            ifid_instr_d = NOP_W;
            ifid_valid_d = 1'b0;
         end else begin
            ifid_instr_d = imem_data;
            ifid_valid_d = 1'b1;
            if (imem_data == HALT_W) begin
               halted_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= '0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         ifid_instr_q  <= NOP_W;
         ifid_pc_q     <= '0;
         ifid_valid_q  <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_valid_q  <= ifid_valid_d;
         halted_q      <= halted_d;
      end
   end

   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_valid = ifid_valid_q;
   assign halted     = halted_q;

endmodule : pipelined_fetch_stage

// File: tb/tb_pipelined_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_pipelined_fetch_stage
//   Directed bench for the IF stage. Instruction memory returns the low 32
//   bits of the fetch address, except in program mode where 0x18 holds the
//   halt marker.
// ---------------------------------------------------------------------------
module tb_pipelined_fetch_stage;

   localparam logic [31:0] NOP  = 32'hD503201F;
   localparam logic [31:0] HALT = 32'h14000000;

   logic        clk;
   logic        reset;
   logic [63:0] imem_addr;
   logic [31:0] imem_data;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic        uncond_br;
   logic [63:0] br_pc;
   logic [25:0] br_imm26;
   logic [18:0] br_imm19;
   logic [31:0] ifid_instr;
   logic [63:0] ifid_pc;
   logic        ifid_valid;
   logic        halted;
   logic        prog_mode;

   int checks = 0;
   int errors = 0;

   pipelined_fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .stall      (stall),
      .flush      (flush),
      .br_taken   (br_taken),
      .uncond_br  (uncond_br),
      .br_pc      (br_pc),
      .br_imm26   (br_imm26),
      .br_imm19   (br_imm19),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .ifid_valid (ifid_valid),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      if (prog_mode && imem_addr == 64'h18) imem_data = HALT;
      else                                  imem_data = imem_addr[31:0];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_br(input logic tk, input logic unc, input logic [63:0] pc,
                         input logic [25:0] i26, input logic [18:0] i19);
      br_taken  = tk;
      uncond_br = unc;
      br_pc     = pc;
      br_imm26  = i26;
      br_imm19  = i19;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; prog_mode = 1'b0;
      set_br(1'b0, 1'b0, 64'h0, 26'h0, 19'h0);

      // Reset state
      step();
      check("rst_valid", 64'(ifid_valid), 64'h0);
      check("rst_instr", 64'(ifid_instr), 64'(NOP));
      check("rst_pc",    imem_addr,       64'h0);
      check("rst_halt",  64'(halted),     64'h0);

      // Free run: 0, 4, 8
      reset = 1'b0;
      step();
      check("run0_pc",    ifid_pc,         64'h0);
      check("run0_valid", 64'(ifid_valid), 64'h1);
      check("run0_instr", 64'(ifid_instr), 64'h0);
      step();
      check("run1_pc",    ifid_pc,         64'h4);
      step();
      check("run2_pc",    ifid_pc,         64'h8);
      check("run2_addr",  imem_addr,       64'hC);

      // B redirect resolved while PC=0x14: target 0x10 + 3*4 = 0x1C
      step();
      step();
      check("pre_b_addr", imem_addr, 64'h14);
      set_br(1'b1, 1'b1, 64'h10, 26'd3, 19'h0);
      step();
      set_br(1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
      check("b_slot_pc", ifid_pc,   64'h14);
      check("b_addr",    imem_addr, 64'h1C);
      step();
      check("b_tgt_pc",  ifid_pc,   64'h1C);
      check("b_next",    imem_addr, 64'h20);

      // Stall for two cycles at 0x20, redirect to 0x100 in stall cycle 1
      stall = 1'b1;
      set_br(1'b1, 1'b1, 64'hF0, 26'd4, 19'h0);
      step();
      set_br(1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
      check("st1_addr",  imem_addr, 64'h20);
      check("st1_ifpc",  ifid_pc,   64'h1C);
      step();
      check("st2_addr",  imem_addr, 64'h20);
      check("st2_ifpc",  ifid_pc,   64'h1C);
      stall = 1'b0;
      step();
      check("st_rel_addr",  imem_addr,       64'h100);
      check("st_rel_ifpc",  ifid_pc,         64'h20);
      check("st_rel_instr", 64'(ifid_instr), 64'h20);

      // Second stall: redirect to 0x100 overridden by 0x200 in cycle 2
      stall = 1'b1;
      set_br(1'b1, 1'b1, 64'hF0, 26'd4, 19'h0);
      step();
      set_br(1'b1, 1'b1, 64'h1F0, 26'd4, 19'h0);
      step();
      check("ovr_hold", imem_addr, 64'h100);
      stall = 1'b0;
      set_br(1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
      step();
      check("ovr_addr", imem_addr, 64'h200);
      check("ovr_ifpc", ifid_pc,   64'h100);
      step();
      check("ovr_done", imem_addr, 64'h204);

      // Backward CBZ: 0x40 + (-2)*4 = 0x38
      set_br(1'b1, 1'b0, 64'h40, 26'h0, 19'h7FFFE);
      step();
      check("cbz_back", imem_addr, 64'h38);
      // 0 + (-1)*4 wraps
      set_br(1'b1, 1'b0, 64'h0, 26'h0, 19'h7FFFF);
      step();
      check("cbz_wrap", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      set_br(1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
      step();
      check("pc_wrap",    imem_addr,       64'h0);
      check("wrap_ifpc",  ifid_pc,         64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_instr", 64'(ifid_instr), 64'hFFFF_FFFC);

      // stall + flush: IF/ID holds
      stall = 1'b1; flush = 1'b1;
      step();
      check("sf_instr", 64'(ifid_instr), 64'hFFFF_FFFC);
      check("sf_valid", 64'(ifid_valid), 64'h1);
      check("sf_addr",  imem_addr,       64'h0);
      // flush alone: bubble, PC advances
      stall = 1'b0;
      step();
      flush = 1'b0;
      check("fl_instr", 64'(ifid_instr), 64'(NOP));
      check("fl_valid", 64'(ifid_valid), 64'h0);
      check("fl_ifpc",  ifid_pc,         64'h0);
      check("fl_addr",  imem_addr,       64'h4);

      // Program with HALT at 0x18
      prog_mode = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check("pre_halt", 64'(halted), 64'h0);
      end
      check("halt_fetch", imem_addr, 64'h18);
      step();
      check("halt_set",   64'(halted),     64'h1);
      check("halt_instr", 64'(ifid_instr), 64'(HALT));
      check("halt_ifpc",  ifid_pc,         64'h18);
      // ID resolves the self-branch while its delay slot is fetched
      set_br(1'b1, 1'b1, 64'h18, 26'h0, 19'h0);
      step();
      set_br(1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
      check("loop_addr", imem_addr,   64'h18);
      check("loop_halt", 64'(halted), 64'h1);
      step();
      check("loop_again", 64'(ifid_instr), 64'(HALT));
      check("halt_stay",  64'(halted),     64'h1);

      // Reset with a stall and pending redirect in flight clears everything
      stall = 1'b1;
      set_br(1'b1, 1'b1, 64'h18, 26'd8, 19'h0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0;
      set_br(1'b0, 1'b0, 64'h0, 26'h0, 19'h0);
      check("rst2_halt",  64'(halted),     64'h0);
      check("rst2_addr",  imem_addr,       64'h0);
      check("rst2_valid", 64'(ifid_valid), 64'h0);
      step();
      check("rst2_nopend", imem_addr, 64'h4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pipelined_fetch_stage
